// File: rtl/dst_hazard_ctrl_pkg.sv
// Shared types for the destination/hazard controller: forwarding encodings,
// controller state encoding and the pipeline tracker entry.
package dst_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FREEZE   = 2'b10
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       reg_write;
        logic       is_load;
    } trk_entry_t;

    localparam trk_entry_t TRK_EMPTY = '{valid: 1'b0, dst: 5'd0, reg_write: 1'b0, is_load: 1'b0};

    // $0 and non-writing entries can never be a forwarding or hazard source.
    function automatic logic entry_match(input trk_entry_t e, input logic [4:0] r);
        return e.valid && e.reg_write && (e.dst != 5'd0) && (e.dst == r);
    endfunction

    function automatic logic [1:0] fwd_select(input trk_entry_t ex_e, input trk_entry_t mem_e,
                                              input logic used, input logic [4:0] r);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && entry_match(ex_e, r)) begin
            sel = FWD_EXMEM;
        end else if (used && entry_match(mem_e, r)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dst_hazard_ctrl_track.sv
// One pipeline tracker entry: a register with advance enable and async clear.
module dst_track_stage
    import dst_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  trk_entry_t d_i,
    output trk_entry_t q_o
);

    trk_entry_t entry_q;

    // Entry register, held while the pipeline is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= TRK_EMPTY;
        end else if (en_i) begin
            entry_q <= d_i;
        end else begin
            entry_q <= entry_q;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/dst_hazard_ctrl.sv
// Destination select, operand forwarding and load-use / memory-busy stall
// control for a 5-stage pipeline.
module dst_hazard_ctrl
    import dst_hazard_ctrl_pkg::*;
#(
    parameter int unsigned RCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              ex_dst_sel,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              bubble,
    output logic [RCNT_W-1:0] stall_count
);

    trk_entry_t        id_entry_s;
    trk_entry_t        ex_s;
    trk_entry_t        mem_s;
    trk_entry_t        wb_s;
    logic              wb_unused_s;
    logic              adv_s;
    state_e            state_q;
    state_e            ret_q;
    state_e            eff_state_s;
    logic              hazard_s;
    logic              lu_stall_s;
    logic              stall_s;
    logic              bubble_s;
    logic              ex_dst_sel_q;
    logic              ex_dst_sel_d;
    logic [1:0]        fwd_a_q;
    logic [1:0]        fwd_a_d;
    logic [1:0]        fwd_b_q;
    logic [1:0]        fwd_b_d;
    logic [RCNT_W-1:0] cnt_q;

    assign adv_s = !mem_busy;

    dst_track_stage u_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (adv_s),
        .d_i   (id_entry_s),
        .q_o   (ex_s)
    );

    dst_track_stage u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (adv_s),
        .d_i   (ex_s),
        .q_o   (mem_s)
    );

    dst_track_stage u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (adv_s),
        .d_i   (mem_s),
        .q_o   (wb_s)
    );

    // WB is tracked for completeness only; the register file writes before it reads.
    assign wb_unused_s = ^wb_s;

    // Hazard detection and stall/bubble priority: mem_busy > flush > load-use.
    always_comb begin
        eff_state_s = (state_q == ST_FREEZE) ? ret_q : state_q;
        hazard_s    = id_valid && ex_s.valid && ex_s.is_load &&
                      ((id_uses_rs && entry_match(ex_s, id_rs)) ||
                       (id_uses_rt && entry_match(ex_s, id_rt)));
        lu_stall_s  = 1'b0;
        stall_s     = 1'b0;
        bubble_s    = 1'b0;
        if (!rst_n) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end else if (mem_busy) begin
            stall_s  = 1'b1;
        end else if (flush) begin
            bubble_s = 1'b1;
        end else begin
            case (eff_state_s)
                ST_RUN: begin
                    lu_stall_s = hazard_s;
                    stall_s    = hazard_s;
                    bubble_s   = hazard_s;
                end
                ST_LU_STALL: begin
                    stall_s  = 1'b0;
                    bubble_s = 1'b0;
                end
                default: begin
                    stall_s  = 1'b0;
                    bubble_s = 1'b0;
                end
            endcase
        end
    end

    // ID-stage entry and the EX-cycle controls that travel with it.
    always_comb begin
        if (bubble_s) begin
            id_entry_s = TRK_EMPTY;
        end else begin
            id_entry_s = '{valid:     id_valid,
                           dst:       id_reg_dst ? id_rd : id_rt,
                           reg_write: id_reg_write,
                           is_load:   id_mem_read};
        end
        if (id_entry_s.valid) begin
            ex_dst_sel_d = id_reg_dst;
            fwd_a_d      = fwd_select(ex_s, mem_s, id_uses_rs, id_rs);
            fwd_b_d      = fwd_select(ex_s, mem_s, id_uses_rt, id_rt);
        end else begin
            ex_dst_sel_d = 1'b0;
            fwd_a_d      = FWD_RF;
            fwd_b_d      = FWD_RF;
        end
    end

    // Controller FSM, registered EX controls and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            ret_q        <= ST_RUN;
            ex_dst_sel_q <= 1'b0;
            fwd_a_q      <= FWD_RF;
            fwd_b_q      <= FWD_RF;
            cnt_q        <= '0;
        end else if (mem_busy) begin
            if (state_q != ST_FREEZE) begin
                ret_q <= state_q;
            end else begin
                ret_q <= ret_q;
            end
            state_q <= ST_FREEZE;
        end else begin
            ex_dst_sel_q <= ex_dst_sel_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            if (lu_stall_s && (cnt_q != '1)) begin
                cnt_q <= cnt_q + RCNT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end
            case (eff_state_s)
                ST_RUN:      state_q <= lu_stall_s ? ST_LU_STALL : ST_RUN;
                ST_LU_STALL: state_q <= ST_RUN;
                default:     state_q <= ST_RUN;
            endcase
        end
    end

    assign stall       = stall_s;
    assign bubble      = bubble_s;
    assign ex_dst_sel  = ex_dst_sel_q;
    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_dst_hazard_ctrl.sv
// Directed bench for dst_hazard_ctrl with a per-cycle behavioural pipeline model.
module tb_dst_hazard_ctrl;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
    logic          id_reg_dst = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic          flush = 1'b0, mem_busy = 1'b0;
    logic          ex_dst_sel, stall, bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    dst_hazard_ctrl #(.RCNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .flush(flush), .mem_busy(mem_busy), .ex_dst_sel(ex_dst_sel), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit v; bit [4:0] d; bit w; bit ld; } rec_t;
    rec_t     pipe [3];          // 0 = EX, 1 = MEM, 2 = WB
    bit       release_cyc;       // cycle right after a load-use stall
    int       mcnt;
    bit [1:0] efa, efb;
    bit       eds;

    function automatic bit hit(input rec_t r, input logic [4:0] a);
        return r.v && r.w && (r.d != 5'd0) && (r.d == a);
    endfunction

    function automatic bit [1:0] mfwd(input bit used, input logic [4:0] r);
        if (!used) return 2'b00;
        if (hit(pipe[0], r)) return 2'b10;
        if (hit(pipe[1], r)) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        bit haz, lu, es, eb;
        bit [1:0] nfa, nfb;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 5'd0, 1'b0, 1'b0};
            release_cyc = 1'b0; mcnt = 0; efa = 2'b00; efb = 2'b00; eds = 1'b0;
            chk("rst_stall", stall, 1'b0);
            chk("rst_bubble", bubble, 1'b0);
            chk("rst_fwd", {fwd_a, fwd_b}, 4'd0);
            chk("rst_dstsel", ex_dst_sel, 1'b0);
            chk("rst_count", stall_count, 0);
        end else begin
            haz = id_valid && pipe[0].v && pipe[0].ld &&
                  ((id_uses_rs && hit(pipe[0], id_rs)) || (id_uses_rt && hit(pipe[0], id_rt)));
            lu  = !mem_busy && !flush && !release_cyc && haz;
            es  = mem_busy || lu;
            eb  = !mem_busy && (flush || lu);
            chk("m_stall", stall, es);
            chk("m_bubble", bubble, eb);
            chk("m_fwd_a", fwd_a, efa);
            chk("m_fwd_b", fwd_b, efb);
            chk("m_dstsel", ex_dst_sel, eds);
            chk("m_count", stall_count, mcnt);
            if (!mem_busy) begin
                nfa = mfwd(id_uses_rs, id_rs);
                nfb = mfwd(id_uses_rt, id_rt);
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (eb || !id_valid) begin
                    pipe[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
                    efa = 2'b00; efb = 2'b00; eds = 1'b0;
                end else begin
                    pipe[0] = '{1'b1, id_reg_dst ? id_rd : id_rt, id_reg_write, id_mem_read};
                    efa = nfa; efb = nfb; eds = id_reg_dst;
                end
                release_cyc = lu;
                if (lu && mcnt < (1 << CW) - 1) mcnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rdst, input logic rw, input logic mr,
                       input logic urs, input logic urt, input logic fl, input logic busy);
        @(posedge clk); #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_reg_dst = rdst;
        id_reg_write = rw; id_mem_read = mr; id_uses_rs = urs; id_uses_rt = urt;
        flush = fl; mem_busy = busy;
        @(negedge clk); #1;
    endtask

    task automatic nop();
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // lw $t, 0($1)
    task automatic lw(input logic [4:0] t);
        cyc(1'b1, 5'd1, t, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // R-type reading rs/rt, writing rd
    task automatic rop(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl, input logic busy);
        cyc(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, fl, busy);
    endtask

    initial begin
        mem_busy = 1'b1;                       // busy during reset must not stall
        repeat (2) @(negedge clk);
        chk("reset_stall", stall, 1'b0);
        chk("reset_count", stall_count, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_busy = 1'b0;
        @(negedge clk); #1;
        chk("post_reset_stall", stall, 1'b0);

        // add $3 ; sub $6,$3,$4
        rop(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        rop(5'd3, 5'd4, 5'd6, 1'b0, 1'b0);
        chk("add_dst_sel", ex_dst_sel, 1'b1);
        nop();
        chk("sub_fwd_a_exmem", fwd_a, 2'b10);
        chk("sub_fwd_b_rf", fwd_b, 2'b00);

        // MEM forward on rt, then no forward from WB
        rop(5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
        nop();
        rop(5'd1, 5'd7, 5'd8, 1'b0, 1'b0);
        nop();
        chk("memwb_fwd_b", fwd_b, 2'b01);
        rop(5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
        nop(); nop();
        rop(5'd9, 5'd2, 5'd17, 1'b0, 1'b0);
        nop();
        chk("no_wb_fwd", fwd_a, 2'b00);

        // lw $5 ; add rs=5
        lw(5'd5);
        rop(5'd5, 5'd2, 5'd10, 1'b0, 1'b0);
        chk("lu_stall", stall, 1'b1);
        chk("lu_bubble", bubble, 1'b1);
        rop(5'd5, 5'd2, 5'd10, 1'b0, 1'b0);
        chk("lu_release_stall", stall, 1'b0);
        chk("lu_count", stall_count, 2'd1);
        nop();
        chk("lu_fwd_a", fwd_a, 2'b01);

        // lw $0 ; use $0
        lw(5'd0);
        rop(5'd0, 5'd2, 5'd18, 1'b0, 1'b0);
        chk("zero_no_stall", stall, 1'b0);
        nop();
        chk("zero_fwd_a", fwd_a, 2'b00);

        // load-use with simultaneous flush
        lw(5'd11);
        rop(5'd11, 5'd2, 5'd19, 1'b1, 1'b0);
        chk("flush_bubble", bubble, 1'b1);
        chk("flush_stall", stall, 1'b0);
        chk("flush_count", stall_count, 2'd1);
        nop();
        chk("flush_fwd_a", fwd_a, 2'b00);

        // mem_busy held 3 cycles during LU_STALL
        lw(5'd12);
        rop(5'd12, 5'd2, 5'd20, 1'b0, 1'b0);
        chk("fz_lu_stall", stall, 1'b1);
        repeat (3) begin
            rop(5'd12, 5'd2, 5'd20, 1'b0, 1'b1);
            chk("fz_stall", stall, 1'b1);
            chk("fz_bubble", bubble, 1'b0);
            chk("fz_count", stall_count, 2'd2);
        end
        rop(5'd12, 5'd2, 5'd20, 1'b0, 1'b0);
        chk("fz_release_stall", stall, 1'b0);
        chk("fz_release_bubble", bubble, 1'b0);
        nop();
        chk("fz_fwd_a", fwd_a, 2'b01);
        chk("fz_no_second_stall", stall, 1'b0);

        // saturation of the 2-bit counter
        lw(5'd13);
        rop(5'd13, 5'd2, 5'd21, 1'b0, 1'b0);
        rop(5'd13, 5'd2, 5'd21, 1'b0, 1'b0);
        chk("sat_count3", stall_count, 2'd3);
        lw(5'd14);
        rop(5'd14, 5'd2, 5'd22, 1'b0, 1'b0);
        chk("sat_stall", stall, 1'b1);
        rop(5'd14, 5'd2, 5'd22, 1'b0, 1'b0);
        chk("sat_hold", stall_count, 2'd3);

        // reset in the middle of a freeze
        lw(5'd15);
        rop(5'd15, 5'd2, 5'd23, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_count", stall_count, 2'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        rop(5'd15, 5'd2, 5'd23, 1'b0, 1'b0);
        chk("after_rst_no_hazard", stall, 1'b0);
        nop();
        chk("after_rst_fwd", fwd_a, 2'b00);
        nop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dst_hazard_ctrl.md
DST_HAZARD_CTRL -- requirements
Module: dst_hazard_ctrl

Interface
REQ-001 SHALL have parameter RCNT_W, default 16, width of the saturating stall counter.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, single clock domain.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: id_valid  in  1  instruction in ID is valid.
REQ-005 SHALL have ports: id_rs, id_rt, id_rd  in  5 each  ID register fields.
REQ-006 SHALL have ports: id_reg_dst  in  1  1 = destination is rd (R-type), 0 = rt.
REQ-007 SHALL have ports: id_reg_write, id_mem_read, id_uses_rs, id_uses_rt  in  1 each  decoded ID controls.
REQ-008 SHALL have ports: flush  in  1  taken branch/jump, kills ID.
REQ-009 SHALL have ports: mem_busy  in  1  memory not ready, freezes the pipeline.
REQ-010 SHALL have ports: ex_dst_sel  out  1  select for the EX-stage 5-bit destination mux (1 = rd).
REQ-011 SHALL have ports: fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-012 SHALL have ports: stall  out  1  hold PC and IF/ID.
REQ-013 SHALL have ports: bubble  out  1  insert NOP into ID/EX.
REQ-014 SHALL have ports: stall_count  out  RCNT_W  load-use stall cycles, saturating.

Function
REQ-015 SHALL track three entries EX, MEM, WB, each {valid, dst[4:0], reg_write, is_load}; dst = id_reg_dst ? id_rd : id_rt at capture.
REQ-016 SHALL, when not frozen, advance each clock: WB<=MEM, MEM<=EX, EX<=ID entry, or an invalid entry if bubble.
REQ-017 SHALL register ex_dst_sel, fwd_a and fwd_b with the ID entry so they are valid during the instruction's EX cycle (latency 1).
REQ-018 SHALL treat a destination of 5'd0, or reg_write=0, as never matching.
REQ-019 SHALL compute fwd_a from id_rs with id_uses_rs: EX entry match -> 10, else MEM match -> 01, else 00; fwd_b likewise from id_rt.
REQ-020 SHALL NOT forward from the WB entry; the register file is write-before-read.
REQ-021 SHALL detect a load-use hazard when id_valid, the EX entry is valid with is_load, and its dst matches a used rs/rt.
REQ-022 SHALL implement FSM RUN, LU_STALL, FREEZE, with RUN as the reset state.
REQ-023 SHALL, in RUN on a load-use hazard, assert stall=1 and bubble=1 combinationally for exactly one cycle, then go to LU_STALL.
REQ-024 SHALL, in LU_STALL, deassert stall and bubble, then return to RUN. The load is now in MEM, so the dependent instruction gets fwd 01.
REQ-025 SHALL, on mem_busy=1 in any state, go to or stay in FREEZE: hold all entries, outputs and stall_count; stall=1, bubble=0.
REQ-026 SHALL, on mem_busy falling, leave FREEZE for the state it was entered from and resume.
REQ-027 SHALL, on flush (not frozen), capture an invalid EX entry (bubble=1), zero fwd_a and fwd_b, and assert stall=0.
REQ-028 SHALL apply priority mem_busy > flush > load-use hazard.
REQ-029 SHALL increment stall_count once per cycle in which a load-use stall is asserted, and hold it at all-ones.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear all entry valid bits and set: FSM to RUN, ex_dst_sel=0, fwd_a=fwd_b=00, stall_count=0.
REQ-031 SHALL drive stall=0 and bubble=0 while rst_n is low.
REQ-032 SHALL discard all tracked state on reset mid-stall or mid-freeze; no hazard may be reported on the first cycle after reset.

Structure
REQ-033 SHALL place the fwd encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB), the FSM state encoding and the tracker-entry typedef in the shared pipeline package.
REQ-034 SHALL use one sub-module, dst_track_stage, instantiated three times: a single entry register with enable and async clear.

Verification
REQ-035 SHALL cover: reset with rst_n=0 for 2 cycles -> all outputs 0, stall_count=0.
REQ-036 SHALL cover: R-type add $3 (reg_dst=1, rd=3), then sub using rs=3 -> next EX cycle ex_dst_sel=1 for add and fwd_a=10 for sub.
REQ-037 SHALL cover: lw $5, then add rs=5 -> stall=bubble=1 for one cycle, then fwd_a=01, stall_count=1.
REQ-038 SHALL cover: lw $0, then use of $0 -> no stall, fwd_a=00.
REQ-039 SHALL cover: load-use hazard with flush in the same cycle -> bubble=1, stall=0, stall_count unchanged.
REQ-040 SHALL cover: mem_busy held 3 cycles during LU_STALL -> entries and outputs frozen, then LU_STALL completes exactly once.
